// File: rtl/dmi_uart_queued_bridge.sv
// UART-TAP <-> Debug Module Interface bridge: queued TAP requests, queued responses,
// a per-handshake watchdog and a sticky error that answers later accesses with BUSY.

module dmi_uart_queued_bridge_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // Head is forced to zero while empty so stale storage never reaches the outputs.
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

module dmi_uart_queued_bridge #(
    parameter int unsigned ABITS      = 7,
    parameter int unsigned REQ_DEPTH  = 4,
    parameter int unsigned RESP_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic             CLK_I,
    input  logic             RST_NI,
    input  logic             TAP_WRITE_VALID_I,
    output logic             TAP_WRITE_READY_O,
    input  logic [ABITS+33:0] TAP_WRITE_DATA_I,
    output logic             TAP_READ_VALID_O,
    input  logic             TAP_READ_READY_I,
    output logic [ABITS+33:0] TAP_READ_DATA_O,
    output logic             DMI_REQ_VALID_O,
    input  logic             DMI_REQ_READY_I,
    output logic [ABITS+33:0] DMI_REQ_O,
    input  logic             DMI_RESP_VALID_I,
    output logic             DMI_RESP_READY_O,
    input  logic [33:0]      DMI_RESP_I,
    output logic             ERR_STICKY_O,
    output logic             BUSY_O
);
    localparam int unsigned W  = ABITS + 34;
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_CLEAR = 2'd3;
    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_FAILED = 2'd2;
    localparam logic [1:0] ERR_BUSY   = 2'd3;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t         state, state_next;
    logic [W-1:0]   req_head, resp_data, cur;
    logic           req_empty, req_full, req_pop;
    logic           resp_empty, resp_full, resp_push;
    logic [CW-1:0]  cnt;
    logic           sticky, sticky_set, sticky_clr, expired;
    logic [ABITS-1:0] head_addr, cur_addr;
    logic [1:0]     head_op;

    assign head_addr = req_head[W-1:34];
    assign head_op   = req_head[1:0];
    assign cur_addr  = cur[W-1:34];
    assign expired   = (cnt == LAST_COUNT);

    dmi_uart_queued_bridge_fifo #(.WIDTH(W), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk       (CLK_I),
        .rst_n     (RST_NI),
        .push      (TAP_WRITE_VALID_I && !req_full),
        .push_data (TAP_WRITE_DATA_I),
        .pop       (req_pop),
        .head      (req_head),
        .full      (req_full),
        .empty     (req_empty)
    );

    dmi_uart_queued_bridge_fifo #(.WIDTH(W), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk       (CLK_I),
        .rst_n     (RST_NI),
        .push      (resp_push),
        .push_data (resp_data),
        .pop       (!resp_empty && TAP_READ_READY_I),
        .head      (TAP_READ_DATA_O),
        .full      (resp_full),
        .empty     (resp_empty)
    );

    assign TAP_WRITE_READY_O = !req_full;
    assign TAP_READ_VALID_O  = !resp_empty;
    assign DMI_REQ_VALID_O   = (state == REQ);
    assign DMI_RESP_READY_O  = (state == RESP);
    assign DMI_REQ_O         = {cur_addr, cur[1:0], cur[33:2]};
    assign ERR_STICKY_O      = sticky;
    assign BUSY_O            = (state != IDLE) || !req_empty;

    always_comb begin
        state_next = state;
        req_pop    = 1'b0;
        resp_push  = 1'b0;
        resp_data  = '0;
        sticky_set = 1'b0;
        sticky_clr = 1'b0;
        case (state)
            IDLE: begin
                // A free response slot is reserved before popping, so the RESP push cannot overflow.
                if (!req_empty && !resp_full) begin
                    req_pop = 1'b1;
                    if (head_op == OP_NOP) begin
                        resp_push = 1'b1;
                        resp_data = {head_addr, 32'h0, sticky ? ERR_BUSY : ERR_OK};
                    end else if (head_op == OP_CLEAR) begin
                        resp_push  = 1'b1;
                        resp_data  = {head_addr, 32'h0, ERR_OK};
                        sticky_clr = 1'b1;
                    end else if (sticky) begin
                        resp_push = 1'b1;
                        resp_data = {head_addr, 32'h0, ERR_BUSY};
                    end else begin
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (DMI_REQ_READY_I) begin
                    state_next = RESP;
                end else if (expired) begin
                    resp_push  = 1'b1;
                    resp_data  = {cur_addr, 32'h0, ERR_FAILED};
                    sticky_set = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (DMI_RESP_VALID_I) begin
                    resp_push  = 1'b1;
                    resp_data  = {cur_addr, DMI_RESP_I};
                    state_next = IDLE;
                end else if (expired) begin
                    resp_push  = 1'b1;
                    resp_data  = {cur_addr, 32'h0, ERR_FAILED};
                    sticky_set = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state  <= IDLE;
            cur    <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            state <= state_next;
            if (req_pop) cur <= req_head;
            if (state_next != state) cnt <= '0;
            else if (state != IDLE)  cnt <= cnt + 1'b1;
            if (sticky_set)      sticky <= 1'b1;
            else if (sticky_clr) sticky <= 1'b0;
        end
    end
endmodule
